// File: rtl/rdmx_xmit_fe_sf.sv
// rdmx_xmit_fe_sf: store-and-forward AXI4 write slave. Each burst is buffered whole, its
// byte count is taken from WSTRB, and a {length, address} header is released ahead of the data.

module rdmx_sf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = PW'(0);
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full queue may still take a push.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

module rdmx_xmit_fe_sf #(
    parameter int DATA_WBITS = 512,
    parameter int ADDR_WBITS = 64,
    parameter int ID_WBITS   = 4,
    parameter int PLEN_WBITS = 16,
    parameter int DATA_DEPTH = 512,
    parameter int PKT_DEPTH  = 8
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [ADDR_WBITS-1:0]            S_AXI_AWADDR,
    input  logic [ID_WBITS-1:0]              S_AXI_AWID,
    input  logic [7:0]                       S_AXI_AWLEN,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [DATA_WBITS-1:0]            S_AXI_WDATA,
    input  logic [DATA_WBITS/8-1:0]          S_AXI_WSTRB,
    input  logic                             S_AXI_WLAST,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [ID_WBITS-1:0]              S_AXI_BID,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [ADDR_WBITS-1:0]            S_AXI_ARADDR,
    input  logic [ID_WBITS-1:0]              S_AXI_ARID,
    input  logic [7:0]                       S_AXI_ARLEN,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [DATA_WBITS-1:0]            S_AXI_RDATA,
    output logic [ID_WBITS-1:0]              S_AXI_RID,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RLAST,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [PLEN_WBITS+ADDR_WBITS-1:0] AXIS_HDR_TDATA,
    output logic                             AXIS_HDR_TVALID,
    input  logic                             AXIS_HDR_TREADY,
    output logic [DATA_WBITS-1:0]            AXIS_DATA_TDATA,
    output logic                             AXIS_DATA_TLAST,
    output logic                             AXIS_DATA_TVALID,
    input  logic                             AXIS_DATA_TREADY
);
    localparam int SW = DATA_WBITS / 8;
    localparam int HW = PLEN_WBITS + ADDR_WBITS;
    localparam int RW = $clog2(DATA_DEPTH + 1) + 1;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

    function automatic logic [PLEN_WBITS-1:0] popcount(input logic [SW-1:0] v);
        logic [PLEN_WBITS-1:0] c;
        c = {PLEN_WBITS{1'b0}};
        for (int i = 0; i < SW; i++) begin
            c = c + PLEN_WBITS'(v[i]);
        end
        return c;
    endfunction

    logic                        run_q;
    logic [PLEN_WBITS-1:0]       byte_acc_q, byte_acc_d, beat_bytes_s;
    logic [RW-1:0]               rel_pkts_q, rel_pkts_d;
    r_state_t                    r_state_q, r_state_d;
    logic [8:0]                  r_beats_q, r_beats_d;
    logic [ID_WBITS-1:0]         r_id_q, r_id_d;

    logic                        aw_empty_s, aw_full_s, aw_push_s;
    logic [ADDR_WBITS+ID_WBITS-1:0] aw_dout_s;
    logic                        hdr_empty_s, hdr_full_s, hdr_pop_s;
    logic                        dat_empty_s, dat_full_s, dat_pop_s;
    logic [DATA_WBITS:0]         dat_dout_s;
    logic                        b_empty_s, b_full_s, b_pop_s;
    logic                        w_ready_s, w_hs_s, w_last_hs_s, dat_last_hs_s;
    logic [HW-1:0]               hdr_din_s;
    logic                        ar_ready_s, r_valid_s, r_last_s;
    logic [1:0]                  r_resp_s;
    logic                        unused_s;

    assign unused_s = ^{S_AXI_AWLEN, S_AXI_ARADDR};

    assign aw_push_s     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_ready_s     = !aw_empty_s && !dat_full_s && !hdr_full_s && !b_full_s;
    assign w_hs_s        = S_AXI_WVALID && w_ready_s;
    assign w_last_hs_s   = w_hs_s && S_AXI_WLAST;
    assign beat_bytes_s  = popcount(S_AXI_WSTRB);
    assign hdr_din_s     = {byte_acc_q + beat_bytes_s, aw_dout_s[ADDR_WBITS+ID_WBITS-1:ID_WBITS]};
    assign hdr_pop_s     = AXIS_HDR_TVALID && AXIS_HDR_TREADY;
    assign dat_pop_s     = AXIS_DATA_TVALID && AXIS_DATA_TREADY;
    assign dat_last_hs_s = dat_pop_s && AXIS_DATA_TLAST;
    assign b_pop_s       = S_AXI_BVALID && S_AXI_BREADY;

    assign S_AXI_AWREADY    = run_q && !aw_full_s;
    assign S_AXI_WREADY     = w_ready_s;
    assign S_AXI_BVALID     = !b_empty_s;
    assign S_AXI_BRESP      = 2'b00;
    assign AXIS_HDR_TVALID  = !hdr_empty_s;
    // Data is only released for packets whose header has already gone out.
    assign AXIS_DATA_TVALID = !dat_empty_s && (rel_pkts_q != RW'(0));
    assign AXIS_DATA_TDATA  = dat_dout_s[DATA_WBITS-1:0];
    assign AXIS_DATA_TLAST  = dat_dout_s[DATA_WBITS];
    assign S_AXI_ARREADY    = ar_ready_s;
    assign S_AXI_RVALID     = r_valid_s;
    assign S_AXI_RRESP      = r_resp_s;
    assign S_AXI_RLAST      = r_last_s;
    assign S_AXI_RID        = r_id_q;
    assign S_AXI_RDATA      = {DATA_WBITS{1'b0}};

    rdmx_sf_fifo #(.WIDTH(ADDR_WBITS + ID_WBITS), .DEPTH(PKT_DEPTH)) u_aw_fifo (
        .clk(clk), .resetn(resetn), .push(aw_push_s), .din({S_AXI_AWADDR, S_AXI_AWID}),
        .pop(w_last_hs_s), .dout(aw_dout_s), .empty(aw_empty_s), .full(aw_full_s)
    );

    rdmx_sf_fifo #(.WIDTH(HW), .DEPTH(PKT_DEPTH)) u_hdr_fifo (
        .clk(clk), .resetn(resetn), .push(w_last_hs_s), .din(hdr_din_s),
        .pop(hdr_pop_s), .dout(AXIS_HDR_TDATA), .empty(hdr_empty_s), .full(hdr_full_s)
    );

    rdmx_sf_fifo #(.WIDTH(DATA_WBITS + 1), .DEPTH(DATA_DEPTH)) u_dat_fifo (
        .clk(clk), .resetn(resetn), .push(w_hs_s), .din({S_AXI_WLAST, S_AXI_WDATA}),
        .pop(dat_pop_s), .dout(dat_dout_s), .empty(dat_empty_s), .full(dat_full_s)
    );

    rdmx_sf_fifo #(.WIDTH(ID_WBITS), .DEPTH(PKT_DEPTH)) u_b_fifo (
        .clk(clk), .resetn(resetn), .push(w_last_hs_s), .din(aw_dout_s[ID_WBITS-1:0]),
        .pop(b_pop_s), .dout(S_AXI_BID), .empty(b_empty_s), .full(b_full_s)
    );

    // Byte accumulation and released-packet bookkeeping.
    always_comb begin
        byte_acc_d = byte_acc_q;
        rel_pkts_d = rel_pkts_q;
        if (w_last_hs_s) begin
            byte_acc_d = {PLEN_WBITS{1'b0}};
        end else if (w_hs_s) begin
            byte_acc_d = byte_acc_q + beat_bytes_s;
        end else begin
            byte_acc_d = byte_acc_q;
        end
        case ({hdr_pop_s, dat_last_hs_s})
            2'b10:   rel_pkts_d = rel_pkts_q + RW'(1);
            2'b01:   rel_pkts_d = rel_pkts_q - RW'(1);
            default: rel_pkts_d = rel_pkts_q;
        endcase
    end

    // Read channel: every burst is answered with SLVERR beats.
    always_comb begin
        r_state_d  = r_state_q;
        r_beats_d  = r_beats_q;
        r_id_d     = r_id_q;
        ar_ready_s = 1'b0;
        r_valid_s  = 1'b0;
        r_resp_s   = 2'b00;
        r_last_s   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_s = run_q;
                if (run_q && S_AXI_ARVALID) begin
                    r_id_d    = S_AXI_ARID;
                    r_beats_d = {1'b0, S_AXI_ARLEN} + 9'd1;
                    r_state_d = R_BURST;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_BURST: begin
                r_valid_s = 1'b1;
                r_resp_s  = 2'b10;
                r_last_s  = (r_beats_q == 9'd1);
                if (S_AXI_RREADY) begin
                    r_beats_d = r_beats_q - 9'd1;
                    if (r_last_s) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_BURST;
                    end
                end else begin
                    r_state_d = R_BURST;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q      <= 1'b0;
            byte_acc_q <= {PLEN_WBITS{1'b0}};
            rel_pkts_q <= RW'(0);
            r_state_q  <= R_IDLE;
            r_beats_q  <= 9'd0;
            r_id_q     <= {ID_WBITS{1'b0}};
        end else begin
            run_q      <= 1'b1;
            byte_acc_q <= byte_acc_d;
            rel_pkts_q <= rel_pkts_d;
            r_state_q  <= r_state_d;
            r_beats_q  <= r_beats_d;
            r_id_q     <= r_id_d;
        end
    end
endmodule

// File: tb/tb_rdmx_xmit_fe_sf.sv
`timescale 1ns/1ps
// Bench for rdmx_xmit_fe_sf: table vectors, hand-written corner sequences and random
// traffic, all scored against a queue-based model of the expected packets.
module tb_rdmx_xmit_fe_sf;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int PW = 16;
    localparam int SW = DW / 8;
    localparam int HW = PW + AW;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr = '0;
    logic [IW-1:0] awid = '0;
    logic [7:0]    awlen = '0;
    logic          awvalid = 1'b0, awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0, wvalid = 1'b0, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, b_rdy;
    logic [AW-1:0] araddr = '0;
    logic [IW-1:0] arid = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0, arready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast, rvalid;
    logic          man_r = 1'b1;
    logic [HW-1:0] hdr_tdata;
    logic          hdr_tvalid, hdr_rdy;
    logic [DW-1:0] dat_tdata;
    logic          dat_tlast, dat_tvalid, dat_rdy;

    logic rnd_mode = 1'b0;
    logic man_hdr = 1'b1, man_dat = 1'b1, man_b = 1'b1;
    logic rnd_hdr = 1'b1, rnd_dat = 1'b1, rnd_b = 1'b1;
    assign hdr_rdy = rnd_mode ? rnd_hdr : man_hdr;
    assign dat_rdy = rnd_mode ? rnd_dat : man_dat;
    assign b_rdy   = rnd_mode ? rnd_b   : man_b;

    rdmx_xmit_fe_sf #(
        .DATA_WBITS(DW), .ADDR_WBITS(AW), .ID_WBITS(IW), .PLEN_WBITS(PW),
        .DATA_DEPTH(512), .PKT_DEPTH(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(b_rdy),
        .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(man_r),
        .AXIS_HDR_TDATA(hdr_tdata), .AXIS_HDR_TVALID(hdr_tvalid), .AXIS_HDR_TREADY(hdr_rdy),
        .AXIS_DATA_TDATA(dat_tdata), .AXIS_DATA_TLAST(dat_tlast),
        .AXIS_DATA_TVALID(dat_tvalid), .AXIS_DATA_TREADY(dat_rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected packets, built from what the master handed over.
    typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; } aw_t;
    aw_t           aw_q[$];
    logic [HW-1:0] exp_hdr_q[$];
    logic [DW:0]   exp_dat_q[$];
    logic [IW-1:0] exp_b_q[$];
    logic [DW:0]   cur_beats[$];
    logic [PW-1:0] cur_bytes = '0;
    int            hdr_sent = 0, pkts_done = 0;
    logic [HW-1:0] last_hdr = '0;
    logic [IW-1:0] last_bid = '0;
    logic [DW:0]   mon_beat;
    logic [HW-1:0] mon_hdr;
    logic [IW-1:0] mon_id;
    aw_t           mon_aw;

    always @(negedge clk) begin
        rnd_hdr = ($urandom_range(0, 3) != 0);
        rnd_dat = ($urandom_range(0, 3) != 0);
        rnd_b   = ($urandom_range(0, 2) != 0);
    end

    // Handshakes are judged mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        #2;
        if (!resetn) begin
            aw_q.delete(); exp_hdr_q.delete(); exp_dat_q.delete(); exp_b_q.delete();
            cur_beats.delete(); cur_bytes = '0; hdr_sent = 0; pkts_done = 0;
        end else begin
            if (dat_tvalid && dat_rdy) begin
                checks++;
                if (exp_dat_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_beat: got unexpected beat last=%0b required none", dat_tlast);
                end else begin
                    mon_beat = exp_dat_q.pop_front();
                    if ({dat_tlast, dat_tdata} !== mon_beat) begin
                        errors++;
                        $display("FAIL data_beat: got %0h required %0h", {dat_tlast, dat_tdata}, mon_beat);
                    end
                end
                chk("data_after_header", (pkts_done < hdr_sent), 1'b1);
                if (dat_tlast) pkts_done++;
            end
            if (hdr_tvalid && hdr_rdy) begin
                checks++;
                if (exp_hdr_q.size() == 0) begin
                    errors++;
                    $display("FAIL header: got %0h required none", hdr_tdata);
                end else begin
                    mon_hdr = exp_hdr_q.pop_front();
                    if (hdr_tdata !== mon_hdr) begin
                        errors++;
                        $display("FAIL header: got %0h required %0h", hdr_tdata, mon_hdr);
                    end
                end
                hdr_sent++;
                last_hdr = hdr_tdata;
            end
            if (bvalid && b_rdy) begin
                checks++;
                if (exp_b_q.size() == 0) begin
                    errors++;
                    $display("FAIL bresp_id: got %0h required none", bid);
                end else begin
                    mon_id = exp_b_q.pop_front();
                    if (bid !== mon_id) begin
                        errors++;
                        $display("FAIL bresp_id: got %0h required %0h", bid, mon_id);
                    end
                end
                chk("bresp_okay", bresp, 2'b00);
                last_bid = bid;
            end
            if (wvalid && wready) begin
                chk("w_has_aw", (aw_q.size() != 0), 1'b1);
                cur_bytes = cur_bytes + PW'($countones(wstrb));
                cur_beats.push_back({wlast, wdata});
                if (wlast && aw_q.size() != 0) begin
                    mon_aw = aw_q.pop_front();
                    exp_hdr_q.push_back({cur_bytes, mon_aw.addr});
                    exp_b_q.push_back(mon_aw.id);
                    foreach (cur_beats[i]) exp_dat_q.push_back(cur_beats[i]);
                    cur_beats.delete();
                    cur_bytes = '0;
                end
            end
            if (awvalid && awready) aw_q.push_back('{awaddr, awid});
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_strb();
        logic [SW-1:0] s;
        for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0:       s = '0;
            1:       s = '1;
            2:       s = s;
            default: s = SW'($urandom_range(0, 255));
        endcase
        return s;
    endfunction

    // Driver tasks start right at a falling edge and return at a falling edge.
    task automatic do_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
        int n = 0;
        awaddr = a; awid = id; awlen = len; awvalid = 1'b1;
        #1;
        while (!awready && n < 1000) begin @(negedge clk); #1; n++; end
        chk("aw_handshake", (n < 1000), 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int nb, input logic [SW-1:0] strb, input bit rnd);
        int n;
        for (int b = 0; b < nb; b++) begin
            wdata = rand_data();
            wstrb = rnd ? rand_strb() : strb;
            wlast = (b == nb - 1);
            wvalid = 1'b1;
            n = 0;
            #1;
            while (!wready && n < 1000) begin @(negedge clk); #1; n++; end
            chk("w_handshake", (n < 1000), 1'b1);
            @(negedge clk);
            if (rnd && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0; wlast = 1'b0;
                @(negedge clk);
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_hdr_q.size() != 0 || exp_dat_q.size() != 0 || exp_b_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, (n < 3000), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        int            beats;
        logic [SW-1:0] strb;
        logic [PW-1:0] plen;
    } vec_t;
    vec_t vt[6];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rbeats, n, h0, nb;
        vt[0] = '{64'h2000, 4'd1, 1, 64'h0000_0000_0000_000F, 16'd4};
        vt[1] = '{64'h2040, 4'd2, 1, 64'h0, 16'd0};
        vt[2] = '{64'h3000, 4'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd64};
        vt[3] = '{64'h4000, 4'd4, 1, 64'h8000_0000_0000_0001, 16'd2};
        vt[4] = '{64'h5000, 4'd5, 2, 64'h0000_0000_0000_FF00, 16'd16};
        vt[5] = '{64'h6000, 4'd6, 3, 64'h0000_0000_0000_000F, 16'd12};

        #2 resetn = 1'b0;
        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_valids", {bvalid, rvalid, hdr_tvalid, dat_tvalid}, 4'b0000);
        chk("rst_resps", {bresp, rresp}, 4'b0000);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        @(negedge clk);

        // Four full-strobe beats: 256 bytes, header the cycle after WLAST.
        do_aw(64'h1000, 4'd3, 8'd3);
        do_w(4, '1, 1'b0);
        #1 chk("hdr_after_wlast", hdr_tvalid, 1'b1);
        @(negedge clk);
        wait_idle("burst4");
        chk("burst4_hdr", last_hdr, {16'd256, 64'h1000});
        chk("burst4_bid", last_bid, 4'd3);

        for (int i = 0; i < 6; i++) begin
            do_aw(vt[i].addr, vt[i].id, 8'(vt[i].beats - 1));
            do_w(vt[i].beats, vt[i].strb, 1'b0);
            wait_idle("table");
            chk("tbl_plen", last_hdr[HW-1:AW], vt[i].plen);
            chk("tbl_addr", last_hdr[AW-1:0], vt[i].addr);
            chk("tbl_bid", last_bid, vt[i].id);
        end

        // W offered five cycles ahead of its AW must be held off.
        fork
            do_w(2, 64'h0000_0000_0000_00FF, 1'b0);
            begin
                for (int i = 0; i < 5; i++) begin
                    #1 chk("w_stall_no_aw", wready, 1'b0);
                    @(negedge clk);
                end
                do_aw(64'h7000, 4'd7, 8'd1);
            end
        join
        wait_idle("w_first");
        chk("w_first_hdr", last_hdr, {16'd16, 64'h7000});

        // Headers held back: no data may leave.
        man_hdr = 1'b0;
        h0 = hdr_sent;
        do_aw(64'hA000, 4'd10, 8'd1); do_w(2, '1, 1'b0);
        do_aw(64'hA100, 4'd11, 8'd0); do_w(1, 64'h3, 1'b0);
        do_aw(64'hA200, 4'd12, 8'd2); do_w(3, 64'h1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1 chk("hold_no_data", dat_tvalid, 1'b0);
            @(negedge clk);
        end
        #1 chk("hold_hdr_valid", hdr_tvalid, 1'b1);
        @(negedge clk);
        man_hdr = 1'b1;
        wait_idle("hdr_hold");
        chk("hold_hdr_count", hdr_sent - h0, 3);
        chk("hold_last_hdr", last_hdr, {16'd3, 64'hA200});

        // Eight unanswered B responses fill the queue.
        man_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_aw(64'hB000 + 64'(i * 64), 4'(i), 8'd0);
            do_w(1, 64'hF, 1'b0);
        end
        do_aw(64'hB800, 4'd9, 8'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bfull_wready", wready, 1'b0);
            @(negedge clk);
        end
        man_b = 1'b1;
        @(negedge clk);
        man_b = 1'b0;
        #1 chk("bpop_wready", wready, 1'b1);
        @(negedge clk);
        do_w(1, 64'hF, 1'b0);
        man_b = 1'b1;
        wait_idle("bfull");
        chk("bfull_last_bid", last_bid, 4'd9);

        // Read burst: three SLVERR beats.
        man_r = 1'b1;
        araddr = 64'hABC0; arid = 4'd5; arlen = 8'd2; arvalid = 1'b1;
        #1 chk("ar_ready_idle", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        rbeats = 0; n = 0;
        while (rbeats < 3 && n < 50) begin
            #1;
            if (rvalid) begin
                chk("r_resp", rresp, 2'b10);
                chk("r_id", rid, 4'd5);
                chk("r_last", rlast, (rbeats == 2));
                chk("r_data_zero", |rdata, 1'b0);
                chk("r_arready_busy", arready, 1'b0);
                rbeats++;
            end
            @(negedge clk);
            n++;
        end
        chk("r_beat_count", rbeats, 3);
        #1 chk("r_done_valid", rvalid, 1'b0);
        chk("r_done_arready", arready, 1'b1);
        @(negedge clk);

        // Reset with a header pending, a B pending, a read burst and a partial write.
        man_hdr = 1'b0; man_b = 1'b0;
        do_aw(64'h8000, 4'd8, 8'd0);
        do_w(1, '1, 1'b0);
        man_r = 1'b0;
        arid = 4'd2; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        do_aw(64'h8800, 4'd9, 8'd3);
        wdata = rand_data(); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
        #1 chk("partial_wready", wready, 1'b1);
        @(negedge clk);
        wvalid = 1'b0;
        #1 chk("pre_rst_valids", {hdr_tvalid, bvalid, rvalid}, 3'b111);
        @(negedge clk);
        resetn = 1'b0;
        #1 chk("midrst_valids", {bvalid, rvalid, hdr_tvalid, dat_tvalid}, 4'b0000);
        chk("midrst_readies", {awready, wready, arready}, 3'b000);
        man_hdr = 1'b1; man_b = 1'b1; man_r = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("after_rst_valids", {bvalid, rvalid, hdr_tvalid, dat_tvalid}, 4'b0000);
        chk("after_rst_readies", {awready, arready}, 2'b11);
        @(negedge clk);
        do_aw(64'h9000, 4'd1, 8'd1);
        do_w(2, 64'h3, 1'b0);
        wait_idle("after_rst");
        chk("after_rst_hdr", last_hdr, {16'd4, 64'h9000});

        // Random traffic with random back-pressure.
        rnd_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 8);
            do_aw({32'h0, $urandom} & 64'hFFFF_FFC0, 4'($urandom_range(0, 15)), 8'(nb - 1));
            do_w(nb, '0, 1'b1);
        end
        wait_idle("random");
        rnd_mode = 1'b0;
        chk("random_all_released", pkts_done, hdr_sent);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
